// File: rtl/mac_16.sv
// Output-stationary 16x16 INT8/INT4 dot-product array with optional per-vector scaling.
// Each active edge adds one dot product per A row into the accumulator column under the pointer.
module mac_16 #(
    parameter int unsigned ROWS       = 16,
    parameter int unsigned COLS       = 16,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned NUM_BLOCKS = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ROWS*264-1:0]          a_vec,
    input  logic [263:0]                 b_vec,
    input  logic                         is_int8_mode,
    input  logic                         is_int4_mode,
    input  logic                         is_vsq,
    output logic [ROWS*COLS*ACC_W-1:0]   latch_array_out
);

    localparam int unsigned OpW      = 264;
    localparam int unsigned Lanes    = 32;
    localparam int unsigned ColW     = $clog2(COLS);
    localparam int unsigned TotalCyc = NUM_BLOCKS * COLS;
    localparam int unsigned CntW     = $clog2(TotalCyc + 1);

    logic [ColW-1:0]  col_q, col_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             frozen_q, frozen_d;
    logic             active;

    logic [ACC_W-1:0] acc_q [ROWS][COLS];
    logic [ACC_W-1:0] acc_d [ROWS][COLS];
    logic [ACC_W-1:0] dot   [ROWS];
    logic [ACC_W-1:0] term  [ROWS];

    // One 8-bit lane: a single INT8 product, or the sum of its two INT4 nibble products.
    // Only the low ACC_W bits matter since the accumulator wraps.
    function automatic logic [ACC_W-1:0] lane_prod(input logic [7:0] a, input logic [7:0] b,
                                                   input logic int8);
        logic signed [15:0] p8;
        logic signed [7:0]  p4_lo;
        logic signed [7:0]  p4_hi;
        p8    = $signed(a) * $signed(b);
        p4_lo = $signed(a[3:0]) * $signed(b[3:0]);
        p4_hi = $signed(a[7:4]) * $signed(b[7:4]);
        if (int8) begin
            return {{(ACC_W-16){p8[15]}}, p8};
        end
        return {{(ACC_W-8){p4_lo[7]}}, p4_lo} + {{(ACC_W-8){p4_hi[7]}}, p4_hi};
    endfunction

    assign active = (is_int8_mode || is_int4_mode) && !frozen_q;

    always_comb begin
        for (int unsigned k = 0; k < ROWS; k++) begin
            dot[k] = '0;
            for (int unsigned e = 0; e < Lanes; e++) begin
                dot[k] = dot[k] + lane_prod(a_vec[k*OpW + 8*e +: 8], b_vec[8*e +: 8],
                                            is_int8_mode);
            end
            if (is_vsq) begin
                term[k] = dot[k] * ACC_W'(a_vec[k*OpW + 256 +: 8]) * ACC_W'(b_vec[263:256]);
            end else begin
                term[k] = dot[k];
            end
        end
    end

    always_comb begin
        acc_d    = acc_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        frozen_d = frozen_q;
        if (active) begin
            for (int unsigned k = 0; k < ROWS; k++) begin
                acc_d[k][col_q] = acc_q[k][col_q] + term[k];
            end
            col_d    = col_q + ColW'(1);
            cnt_d    = cnt_q + CntW'(1);
            frozen_d = (cnt_d == CntW'(TotalCyc));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < ROWS; k++) begin
                for (int unsigned j = 0; j < COLS; j++) begin
                    acc_q[k][j] <= '0;
                end
            end
            col_q    <= '0;
            cnt_q    <= '0;
            frozen_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            frozen_q <= frozen_d;
        end
    end

    for (genvar k = 0; k < ROWS; k++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            assign latch_array_out[(k*COLS + j)*ACC_W +: ACC_W] = acc_q[k][j];
        end
    end

endmodule

// File: tb/tb_mac_16.sv
// Directed and randomized checks of mac_16 against an arithmetic reference model.
module tb_mac_16;

    localparam int R   = 16;
    localparam int C   = 16;
    localparam int OPW = 264;
    localparam int OW  = R*C*24;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [R*OPW-1:0] a_vec;
    logic [OPW-1:0]  b_vec;
    logic            m8, m4, vsq;
    logic [OW-1:0]   out;

    int n_assert = 0;
    int n_fail   = 0;

    longint acc_m [R][C];
    int     col_m;
    int     cyc_m;

    always #5 clk = ~clk;

    mac_16 dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a_vec           (a_vec),
        .b_vec           (b_vec),
        .is_int8_mode    (m8),
        .is_int4_mode    (m4),
        .is_vsq          (vsq),
        .latch_array_out (out)
    );

    function automatic longint dot_model(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                         input logic int8);
        longint s = 0;
        logic signed [7:0] x8, y8;
        logic signed [3:0] x4, y4;
        if (int8) begin
            for (int e = 0; e < 32; e++) begin
                x8 = a[8*e +: 8];
                y8 = b[8*e +: 8];
                s += longint'(x8) * longint'(y8);
            end
        end else begin
            for (int e = 0; e < 64; e++) begin
                x4 = a[4*e +: 4];
                y4 = b[4*e +: 4];
                s += longint'(x4) * longint'(y4);
            end
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < R; k++)
            for (int j = 0; j < C; j++) acc_m[k][j] = 0;
        col_m = 0;
        cyc_m = 0;
    endtask

    task automatic model_edge();
        logic [OPW-1:0] ak;
        longint t, sa, sb;
        if (!(m8 || m4) || cyc_m == 2048) return;
        sb = b_vec[263:256];
        for (int k = 0; k < R; k++) begin
            ak = a_vec[k*OPW +: OPW];
            sa = ak[263:256];
            t  = dot_model(ak, b_vec, m8);
            if (vsq) t = t * sa * sb;
            acc_m[k][col_m] = (acc_m[k][col_m] + t) & 64'hFFFFFF;
        end
        col_m = (col_m + 1) % C;
        cyc_m++;
    endtask

    function automatic logic [OW-1:0] exp_vec();
        logic [OW-1:0] v;
        for (int k = 0; k < R; k++)
            for (int j = 0; j < C; j++) v[(k*C + j)*24 +: 24] = 24'(acc_m[k][j]);
        return v;
    endfunction

    function automatic logic [OPW-1:0] make_op(input logic [7:0] elem, input logic [7:0] scale);
        return {scale, {32{elem}}};
    endfunction

    function automatic logic [R*OPW-1:0] rand_a();
        logic [R*OPW-1:0] v;
        for (int i = 0; i < R*OPW/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [OPW-1:0] rand_b();
        logic [287:0] v;
        for (int i = 0; i < 9; i++) v[32*i +: 32] = $urandom;
        return v[OPW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            for (int i = 0; i < R*C; i++) begin
                if (obs[24*i +: 24] !== exp[24*i +: 24]) begin
                    $error("FAIL %s acc[%0d][%0d]: observed %h expected %h", tag, i / C, i % C,
                           obs[24*i +: 24], exp[24*i +: 24]);
                    break;
                end
            end
        end
    endtask

    task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [23:0] acc_at(input int k, input int j);
        return out[(k*C + j)*24 +: 24];
    endfunction

    initial begin
        logic [OW-1:0] fill;
        rst_n = 1'b0;
        a_vec = '0;
        b_vec = '0;
        m8    = 1'b0;
        m4    = 1'b0;
        vsq   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", out, '0);
        rst_n = 1'b1;

        // INT4: -1 x 3 over 64 nibbles
        a_vec = {R{make_op(8'hFF, 8'h00)}};
        b_vec = make_op(8'h33, 8'h00);
        m4    = 1'b1;
        step();
        chk("int4_model", out, exp_vec());
        chk24("int4_acc0_0", acc_at(0, 0), 24'hFFFF40);
        chk24("int4_acc15_0", acc_at(15, 0), 24'hFFFF40);
        chk24("int4_acc0_1", acc_at(0, 1), 24'h000000);

        // VSQ, plain INT8, and an idle edge that must not move the pointer
        do_reset();
        a_vec = {R{make_op(8'h01, 8'd2)}};
        b_vec = make_op(8'h01, 8'd3);
        m4    = 1'b0;
        m8    = 1'b1;
        vsq   = 1'b1;
        step();
        chk24("vsq_acc0_0", acc_at(0, 0), 24'd192);
        chk24("vsq_acc7_0", acc_at(7, 0), 24'd192);
        vsq = 1'b0;
        step();
        chk24("novsq_acc0_1", acc_at(0, 1), 24'd32);
        m8 = 1'b0;
        step();
        chk("idle_hold", out, exp_vec());
        m8 = 1'b1;
        step();
        chk24("after_idle_acc3_2", acc_at(3, 2), 24'd32);
        chk("after_idle_model", out, exp_vec());

        // Asynchronous reset mid-accumulation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            a_vec = rand_a();
            b_vec = rand_b();
            vsq   = 1'($urandom);
            step();
        end
        chk("pre_async_reset", out, exp_vec());
        #2 rst_n = 1'b0;
        #1 chk("async_reset_zero", out, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        a_vec = rand_a();
        b_vec = rand_b();
        step();
        chk("first_edge_col0", out, exp_vec());

        // Single INT8 block: 1 x 2 over 32 lanes = 64 per edge
        do_reset();
        a_vec = {R{make_op(8'h01, 8'h00)}};
        b_vec = make_op(8'h02, 8'h00);
        vsq   = 1'b0;
        repeat (16) step();
        for (int i = 0; i < R*C; i++) fill[24*i +: 24] = 24'h000040;
        chk("int8_block", out, fill);

        // Full random run to the freeze point, then stale cycles
        do_reset();
        for (int i = 0; i < 2048; i++) begin
            if (i % 16 == 0) a_vec = rand_a();
            b_vec = rand_b();
            m4    = 1'($urandom);
            vsq   = 1'($urandom);
            step();
            if (i % 128 == 127) chk("full_run", out, exp_vec());
        end
        fill = exp_vec();
        repeat (10) step();
        chk("frozen_hold_model", out, exp_vec());
        chk("frozen_hold", out, fill);
        b_vec = rand_b();
        repeat (3) step();
        chk("frozen_new_b", out, fill);

        // Wrap with both mode bits set: -128 x -128 x 32 = 0x80000 per hit
        do_reset();
        a_vec = {R{make_op(8'h80, 8'h00)}};
        b_vec = make_op(8'h80, 8'h00);
        m8    = 1'b1;
        m4    = 1'b1;
        vsq   = 1'b0;
        repeat (241) step();
        chk24("wrap_acc0_0", acc_at(0, 0), 24'h800000);
        chk24("pre_wrap_acc0_1", acc_at(0, 1), 24'h780000);
        chk("wrap_model", out, exp_vec());

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_16.md
Name: mac_16

Overview:
- 16x16 output-stationary INT8/INT4 dot-product array with optional per-vector scaling (VSQ).
- Sixteen stationary A rows are dotted with one streamed B vector per clock. Each result accumulates into a 24-bit latch-array entry selected by an internal column pointer.
- Sits between the A/B operand SRAM readers and the output SRAM writer.
- After a full run (NUM_BLOCKS x 16 accumulation cycles) the array freezes and holds its results.

Parameters:
- ROWS, 16, number of A rows and of accumulator rows
- COLS, 16, number of B vectors per block and of accumulator columns
- ACC_W, 24, accumulator width in bits, two's complement
- NUM_BLOCKS, 128, blocks accumulated before the array freezes

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- a_vec  input  4224  16 A rows; row k = a_vec[264k+263:264k]
- b_vec  input  264  current B vector
- is_int8_mode  input  1  INT8 element mode
- is_int4_mode  input  1  INT4 element mode
- is_vsq  input  1  apply per-vector scale factors
- latch_array_out  output  6144  acc[k][j] = latch_array_out[384k+24j +: 24]

Behaviour:
- Operand format (264 bits): bits[255:0] are elements, bits[263:256] are an unsigned 8-bit scale.
- INT8: 32 signed elements; element e = bits[8e+7:8e].
- INT4: 64 signed elements; element e = bits[4e+3:4e].
- Mode: is_int8_mode has priority over is_int4_mode. Neither set = idle; all state holds and the pointer does not advance.
- Dot product: dot_k = signed sum over all elements of a_k[e]*b[e], computed at full precision.
- VSQ: if is_vsq=1, term_k = dot_k * scale_a_k * scale_b; otherwise term_k = dot_k. Scales are unsigned.
- Accumulate: on each active rising edge (mode set, not frozen), acc[k][col] <= acc[k][col] + term_k for all 16 rows in parallel.
  - The sum is truncated to 24 bits (wrap-around, no saturation).
  - Inputs are sampled at that edge.
- Column pointer col: 4 bits, reset 0, increments mod 16 on each active edge. Blocks of 16 consecutive B vectors map to columns 0..15.
- a_vec may change at any edge; each edge uses its own sampled value.
- Cycle counter: counts active edges, 0 to NUM_BLOCKS*16.
  - When it reaches 2048, the array is frozen: no further accumulation, and extra cycles with stale b_vec have no effect.
  - The frozen state holds until reset.
- Output: latch_array_out is the accumulator registers directly. An accumulation is visible immediately after its edge (latency 1 edge).
- Reset (asynchronous, any time including mid-run):
  - all 256 accumulators <= 0, col <= 0, cycle counter <= 0, frozen flag cleared;
  - latch_array_out = 0 while rst_n=0.
- Mode switching mid-run: allowed; each edge uses that edge's mode. Not a supported use case.
- Implementation sizing: 16 parallel 32-lane INT8 multiplier trees with INT4 reuse of the lanes, plus 256 x 24-bit registers.

Test Plan:
- Reset: assert rst_n=0 mid-accumulation -> all 6144 output bits 0 at once; after release, the first active edge writes column 0.
- INT8 single block: every A element = 1, every B element = 2, is_vsq=0, 16 edges -> every acc = 64 (0x000040), and further edges continue only until 2048 total.
- INT8 full run: 2048 edges of random A (changed every 16 edges) and random B -> each acc equals a software golden model (mod 2^24); 10 extra cycles with b_vec held -> outputs unchanged.
- INT4 mode: all A elements = -1 (0xF), all B elements = 3, one edge -> acc[k][0] = -192 (0xFFFF40) for all k, other columns 0.
- VSQ: A elements = 1, B elements = 1, scale_a = 2, scale_b = 3, is_vsq=1, one INT8 edge -> acc[k][0] = 192. Same with is_vsq=0 -> 32.
- Wrap/priority: both mode bits set -> INT8 interpretation. Preload acc near 0x7FFFFF via repeated max products -> the result wraps to a negative value with no saturation.
